mem_rd_mux_rr: RTL and testbench

Parametrised N-source read-port multiplexer for flow-state memories (rx state, tx state, tuple tables) in the TCP engines. It arbitrates `NUM_SRC` read requesters round-robin onto one backpressured memory read port. It tracks up to `MAX_OUTSTANDING` in-flight reads and routes each in-order response back to the source that issued it. It replaces fixed two-source, single-outstanding muxing wherever more than two engines (proto calc, timeout, retransmit, debug) share a state RAM.

---
 rtl/mem_rd_mux_rr_pkg.sv | 13 +
 rtl/mem_rd_mux_rr_arbiter.sv | 75 +++++++
 rtl/mem_rd_mux_rr.sv | 146 ++++++++++++++
 tb/tb_mem_rd_mux_rr.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_mux_rr_pkg.sv
// mem_rd_mux_rr_pkg
//   Shared helpers for the flow-state memory read-port multiplexer.
//   No ports; provides the index-width helper used to size source tags,
//   arbiter indices and FIFO pointers so a degenerate size of one still
//   yields a legal one-bit vector.
package mem_rd_mux_rr_pkg;

  // Width of an index able to address n entries, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rd_mux_rr_arbiter.sv
// rr_arbiter_lock
//   Round-robin arbiter with a grant lock, shared by memory read muxes and
//   sched update muxes.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     req        : per-source request valid
//     stall      : current grant is offered downstream but not accepted
//     accept     : current grant is accepted downstream (handshake)
//     any_req    : at least one request is pending
//     grant      : index of the granted source
//   The search starts one past the last accepted source. Once an offer is
//   stalled the grant is frozen on that source until it is accepted, so the
//   downstream address cannot change under backpressure.
module rr_arbiter_lock
  import mem_rd_mux_rr_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               stall,
  input  logic               accept,
  output logic               any_req,
  output logic [IDX_W-1:0]   grant
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] locked_idx;
  logic             lock;
  logic [IDX_W-1:0] rr_pick;
  logic [IDX_W-1:0] cand;
  logic             found;

  assign any_req = |req;

  // First asserted request scanning last_grant+1, last_grant+2, ... with
  // wrap; last_grant itself is visited last.
  always_comb begin
    rr_pick = last_grant;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  assign grant = lock ? locked_idx : rr_pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_SRC - 1);
      lock       <= 1'b0;
      locked_idx <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        lock       <= 1'b0;
      end else if (stall) begin
        lock       <= 1'b1;
        locked_idx <= grant;
      end
    end
  end

  // A locked source must hold its request until it is accepted.
  a_lock_held : assert property (@(posedge clk) disable iff (rst)
    lock |-> req[locked_idx]);

endmodule

// File: rtl/mem_rd_mux_rr.sv
// mem_rd_mux_rr
//   N-source read-port multiplexer for flow-state memories. Requests are
//   arbitrated round-robin onto one backpressured memory read port; up to
//   MAX_OUTSTANDING reads may be in flight, and the in-order responses are
//   steered back to the issuing source via a tag FIFO.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     src_rd_req_val    : per-source request valid
//     src_rd_req_addr   : packed addresses, source i at [i*ADDR_W +: ADDR_W]
//     src_rd_req_rdy    : per-source request accept (granted source only)
//     src_rd_resp_val   : one-hot response valid (FIFO head source)
//     src_rd_resp_data  : response data broadcast to all sources
//     src_rd_resp_rdy   : per-source response ready
//     dst_rd_req_*      : memory request port
//     dst_rd_resp_*     : memory response port
//     outstanding_cnt   : number of in-flight reads (registered)
module mem_rd_mux_rr
  import mem_rd_mux_rr_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_rd_req_val,
  input  logic [NUM_SRC*ADDR_W-1:0]         src_rd_req_addr,
  output logic [NUM_SRC-1:0]                src_rd_req_rdy,
  output logic [NUM_SRC-1:0]                src_rd_resp_val,
  output logic [DATA_W-1:0]                 src_rd_resp_data,
  input  logic [NUM_SRC-1:0]                src_rd_resp_rdy,
  output logic                              dst_rd_req_val,
  output logic [ADDR_W-1:0]                 dst_rd_req_addr,
  input  logic                              dst_rd_req_rdy,
  input  logic                              dst_rd_resp_val,
  input  logic [DATA_W-1:0]                 dst_rd_resp_data,
  output logic                              dst_rd_resp_rdy,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_cnt
);

  localparam int unsigned TAG_W = idx_width(NUM_SRC);
  localparam int unsigned PTR_W = idx_width(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [TAG_W-1:0] grant;
  logic             any_req;
  logic             has_room;
  logic             push;
  logic             pop;
  logic             empty;
  logic [TAG_W-1:0] head;

  logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------
  rr_arbiter_lock #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (TAG_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (src_rd_req_val),
    .stall   (dst_rd_req_val & ~dst_rd_req_rdy),
    .accept  (push),
    .any_req (any_req),
    .grant   (grant)
  );

  // Room is judged on the registered count only: a response popped in
  // the same cycle does not free a slot until the next cycle, which also
  // keeps dst_rd_req_rdy out of the dst_rd_req_val cone.
  assign has_room        = outstanding_cnt < CNT_W'(MAX_OUTSTANDING);
  assign dst_rd_req_val  = any_req & has_room;
  assign dst_rd_req_addr = src_rd_req_addr[grant*ADDR_W +: ADDR_W];
  assign push            = dst_rd_req_val & dst_rd_req_rdy;

  always_comb begin
    src_rd_req_rdy = '0;
    if (push) begin
      src_rd_req_rdy[grant] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------
  assign empty            = (outstanding_cnt == '0);
  assign head             = tag_mem[rd_ptr];
  assign dst_rd_resp_rdy  = ~empty & src_rd_resp_rdy[head];
  assign pop              = dst_rd_resp_val & dst_rd_resp_rdy;
  assign src_rd_resp_data = dst_rd_resp_data;

  always_comb begin
    src_rd_resp_val = '0;
    if (!empty) begin
      src_rd_resp_val[head] = dst_rd_resp_val;
    end
  end

  // ---------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------
  // Storage needs no reset: entries are only read when the count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      outstanding_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
        2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

  // The memory must never answer a read that was not issued.
  a_no_resp_when_empty : assert property (@(posedge clk) disable iff (rst)
    !(dst_rd_resp_val && empty));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && !has_room));

endmodule

// File: tb/tb_mem_rd_mux_rr.sv
module tb_mem_rd_mux_rr;

  localparam int NS  = 4;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_val;
  logic [31:0] req_addr;
  logic [3:0]  req_rdy;
  logic [3:0]  resp_val;
  logic [63:0] resp_data;
  logic [3:0]  resp_rdy;
  logic        dst_rd_req_val;
  logic [7:0]  dst_rd_req_addr;
  logic        dst_req_rdy;
  logic        dst_resp_val;
  logic [63:0] dst_resp_data;
  logic        dst_rd_resp_rdy;
  logic [2:0]  outstanding_cnt;

  mem_rd_mux_rr #(
    .NUM_SRC         (NS),
    .ADDR_W          (8),
    .DATA_W          (64),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src_rd_req_val   (req_val),
    .src_rd_req_addr  (req_addr),
    .src_rd_req_rdy   (req_rdy),
    .src_rd_resp_val  (resp_val),
    .src_rd_resp_data (resp_data),
    .src_rd_resp_rdy  (resp_rdy),
    .dst_rd_req_val   (dst_rd_req_val),
    .dst_rd_req_addr  (dst_rd_req_addr),
    .dst_rd_req_rdy   (dst_req_rdy),
    .dst_rd_resp_val  (dst_resp_val),
    .dst_rd_resp_data (dst_resp_data),
    .dst_rd_resp_rdy  (dst_rd_resp_rdy),
    .outstanding_cnt  (outstanding_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [7:0] a);
    if (a == 8'h12) return 64'hAA;
    return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Memory model: in-order, fixed latency, can withhold responses.
  typedef struct { logic [7:0] addr; int due; } pend_t;
  pend_t pending[$];
  int    cyc = 0;
  int    mem_lat = 1;
  bit    mem_block = 1'b0;

  always @(posedge clk) begin
    #2;
    if (!mem_block && pending.size() > 0 && pending[0].due <= cyc) begin
      dst_resp_val  = 1'b1;
      dst_resp_data = mem_word(pending[0].addr);
    end else begin
      dst_resp_val  = 1'b0;
      dst_resp_data = '0;
    end
  end

  // Reference model and scoreboard of expected responses.
  typedef struct { int src; logic [63:0] data; } exp_t;
  exp_t sb[$];
  int   r_last = NS - 1;
  bit   r_lock = 1'b0;
  int   r_lidx = 0;
  int   r_cnt  = 0;

  always @(negedge clk) begin
    int         g;
    bit         found;
    bit         e_val, push, pop, e_rrdy;
    logic [7:0] e_addr;
    logic [3:0] e_srdy, e_rval;

    g = r_last;
    found = 1'b0;
    for (int k = 1; k <= NS; k++) begin
      int c;
      c = (r_last + k) % NS;
      if (!found && req_val[c]) begin
        g = c;
        found = 1'b1;
      end
    end
    if (r_lock) g = r_lidx;
    e_val  = (req_val != 4'b0) && (r_cnt < MAX);
    e_addr = req_addr[g*8 +: 8];
    push   = e_val && dst_req_rdy;
    e_srdy = push ? (4'b0001 << g) : 4'b0000;
    e_rval = 4'b0000;
    e_rrdy = 1'b0;
    if (sb.size() > 0) begin
      e_rval = dst_resp_val ? (4'b0001 << sb[0].src) : 4'b0000;
      e_rrdy = resp_rdy[sb[0].src];
    end
    pop = dst_resp_val && e_rrdy;

    if (!rst) begin
      check_eq("req_val", dst_rd_req_val, e_val);
      if (e_val) check_eq("req_addr", dst_rd_req_addr, e_addr);
      check_eq("req_rdy", req_rdy, e_srdy);
      check_eq("resp_val", resp_val, e_rval);
      check_eq("resp_rdy", dst_rd_resp_rdy, e_rrdy);
      check_eq("cnt", outstanding_cnt, r_cnt);
      if (pop) check_eq("resp_data", resp_data, sb[0].data);
    end

    // Memory side follows the DUT's actual handshakes.
    if (rst) begin
      pending.delete();
    end else begin
      if (dst_rd_req_val && dst_req_rdy)
        pending.push_back('{addr: dst_rd_req_addr, due: cyc + mem_lat});
      if (dst_resp_val && dst_rd_resp_rdy && pending.size() > 0)
        void'(pending.pop_front());
    end

    if (rst) begin
      sb.delete();
      r_last = NS - 1;
      r_lock = 1'b0;
      r_lidx = 0;
      r_cnt  = 0;
    end else begin
      if (push) begin
        sb.push_back('{src: g, data: mem_word(e_addr)});
        r_last = g;
        r_lock = 1'b0;
      end else if (e_val && !dst_req_rdy) begin
        r_lock = 1'b1;
        r_lidx = g;
      end
      if (pop) void'(sb.pop_front());
      r_cnt = r_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input bit v, input logic [7:0] a);
    req_val[i] = v;
    req_addr[i*8 +: 8] = a;
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0 && pending.size() == 0) break;
      tick();
    end
    check_eq("drain_sb_left", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_val = '0;
    req_addr = '0;
    resp_rdy = 4'b1111;
    dst_req_rdy = 1'b1;
    dst_resp_val = 1'b0;
    dst_resp_data = '0;
    repeat (3) tick();
    #2;
    check_eq("reset_cnt", outstanding_cnt, 0);
    check_eq("reset_resp_val", resp_val, 4'b0000);
    check_eq("reset_resp_rdy", dst_rd_resp_rdy, 1'b0);
    tick();
    rst = 1'b0;

    // Single source, latency 3
    mem_lat = 3;
    set_src(1, 1'b1, 8'h12);
    #2;
    check_eq("single_grant", req_rdy, 4'b0010);
    tick();
    set_src(1, 1'b0, 8'h12);
    #2;
    check_eq("single_cnt1", outstanding_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      if (resp_val != 4'b0000) break;
      tick();
      #2;
    end
    check_eq("single_resp_val", resp_val, 4'b0010);
    check_eq("single_resp_data", resp_data, 64'hAA);
    tick();
    #2;
    check_eq("single_cnt0", outstanding_cnt, 0);
    tick();

    // Fairness from a fresh reset: grants 0,1,2,3,0,...
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_lat = 2;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 8'(8'h20 + i));
    for (int k = 0; k < 12; k++) begin
      #2;
      check_eq($sformatf("fair_grant%0d", k), req_rdy, 4'b0001 << (k % NS));
      tick();
    end
    req_val = '0;
    drain();

    // Full: responses withheld, four accepted, then no bypass on pop
    mem_lat = 1;
    mem_block = 1'b1;
    set_src(0, 1'b1, 8'h30);
    repeat (6) tick();
    #2;
    check_eq("full_req_val", dst_rd_req_val, 1'b0);
    check_eq("full_cnt", outstanding_cnt, MAX);
    mem_block = 1'b0;
    tick();
    #2;
    check_eq("full_resp_val", resp_val, 4'b0001);
    check_eq("full_no_bypass", dst_rd_req_val, 1'b0);
    mem_block = 1'b1;
    tick();
    #2;
    check_eq("full_freed_cnt", outstanding_cnt, MAX - 1);
    check_eq("full_freed_val", dst_rd_req_val, 1'b1);
    tick();
    set_src(0, 1'b0, 8'h30);
    mem_block = 1'b0;
    drain();

    // Lock: src2 stalled 5 cycles, src3 waits for src2 handshake
    set_src(2, 1'b1, 8'h42);
    set_src(3, 1'b1, 8'h43);
    dst_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check_eq($sformatf("lock_addr%0d", i), dst_rd_req_addr, 8'h42);
      tick();
    end
    dst_req_rdy = 1'b1;
    #2;
    check_eq("lock_accept2", req_rdy, 4'b0100);
    tick();
    set_src(2, 1'b0, 8'h42);
    #2;
    check_eq("lock_accept3", req_rdy, 4'b1000);
    check_eq("lock_addr3", dst_rd_req_addr, 8'h43);
    tick();
    set_src(3, 1'b0, 8'h43);
    drain();

    // Response backpressure: src0 head blocks src1's response
    resp_rdy[0] = 1'b0;
    set_src(0, 1'b1, 8'h50);
    set_src(1, 1'b1, 8'h51);
    tick();
    set_src(0, 1'b0, 8'h50);
    tick();
    set_src(1, 1'b0, 8'h51);
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq($sformatf("bp_dst_rdy%0d", i), dst_rd_resp_rdy, 1'b0);
      check_eq($sformatf("bp_resp_val%0d", i), resp_val, 4'b0001);
      tick();
    end
    #0;
    check_eq("bp_cnt", outstanding_cnt, 2);
    resp_rdy[0] = 1'b1;
    #2;
    check_eq("bp_release_rdy", dst_rd_resp_rdy, 1'b1);
    tick();
    #2;
    check_eq("bp_src1_val", resp_val, 4'b0010);
    check_eq("bp_src1_data", resp_data, mem_word(8'h51));
    tick();
    drain();

    // Reset with three reads in flight
    mem_block = 1'b1;
    set_src(1, 1'b1, 8'h61);
    repeat (3) tick();
    set_src(1, 1'b0, 8'h61);
    #2;
    check_eq("rst_pre_cnt", outstanding_cnt, 3);
    tick();
    rst = 1'b1;
    tick();
    #2;
    check_eq("rst_cnt", outstanding_cnt, 0);
    check_eq("rst_dst_rdy", dst_rd_resp_rdy, 1'b0);
    check_eq("rst_resp_val", resp_val, 4'b0000);
    mem_block = 1'b0;
    tick();
    rst = 1'b0;
    set_src(0, 1'b1, 8'h70);
    set_src(3, 1'b1, 8'h73);
    #2;
    check_eq("rst_first_grant", req_rdy, 4'b0001);
    check_eq("rst_first_addr", dst_rd_req_addr, 8'h70);
    tick();
    set_src(0, 1'b0, 8'h70);
    #2;
    check_eq("rst_second_grant", req_rdy, 4'b1000);
    tick();
    set_src(3, 1'b0, 8'h73);
    drain();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
